// File: rtl/lcd_text_arbiter_if.sv
// lcd_text_arbiter_if
// Bundles the requester-facing and engine-facing signals of the LCD text
// arbiter into one interface.
//   req, req_line, req_text : per-requester request level, line select and text
//   grant, ack, err, busy   : arbitration status returned to the requesters
//   lcd_sendText, lcd_line,
//   lcd_text, lcd_done      : start pulse, latched message and done level of
//                             the shared LCD text-send engine
// Modports:
//   slave  : the arbiter (consumes requests and engine done, drives the rest)
//   master : the application side plus engine (drives requests and done)
interface lcd_text_arbiter_if #(
    parameter int NUM_REQ     = 2,
    parameter int TEXT_LENGTH = 34
);
    logic [NUM_REQ-1:0]               req;
    logic [NUM_REQ-1:0]               req_line;
    logic [NUM_REQ*8*TEXT_LENGTH-1:0] req_text;
    logic [NUM_REQ-1:0]               grant;
    logic [NUM_REQ-1:0]               ack;
    logic                             err;
    logic                             busy;
    logic                             lcd_sendText;
    logic                             lcd_line;
    logic [8*TEXT_LENGTH-1:0]         lcd_text;
    logic                             lcd_done;

    modport slave (
        input  req, req_line, req_text, lcd_done,
        output grant, ack, err, busy, lcd_sendText, lcd_line, lcd_text
    );

    modport master (
        output req, req_line, req_text, lcd_done,
        input  grant, ack, err, busy, lcd_sendText, lcd_line, lcd_text
    );
endinterface

// File: rtl/lcd_text_arbiter.sv
// lcd_text_arbiter
// Shares the single LCD text-send engine between NUM_REQ requesters using a
// round-robin grant. The winner's text and line select are latched, the
// engine is started with a one-cycle pulse, and the requester is acked when
// the engine's done level rises (or flagged with err after a timeout).
// Ports:
//   CLK : system clock
//   RST : synchronous, active-high reset
//   bus : lcd_text_arbiter_if.slave carrying requests, grant/ack/err/busy and
//         the engine's sendText/line/text/done signals
module lcd_text_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TEXT_LENGTH    = 34,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic              CLK,
    input  logic              RST,
    lcd_text_arbiter_if.slave bus
);
    localparam int TW = 8 * TEXT_LENGTH;
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [25:0] TIMEOUT_LAST = 26'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [IW-1:0]   winner_q, winner_d;
    logic [25:0]     count_q, count_d;
    logic            err_flag_q, err_flag_d;
    logic            line_q, line_d;
    logic [TW-1:0]   text_q, text_d;
    logic            done_q;
    logic            completion;
    logic            found;
    logic [IW-1:0]   pick;
    logic            busy;

    // Only a rising edge of the engine's done level counts; a level left high
    // by a previous message must fall and rise again.
    assign completion = bus.lcd_done & ~done_q;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        found = 1'b0;
        pick  = last_grant_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int cand;
            cand = (int'(last_grant_q) + i) % NUM_REQ;
            if (!found && bus.req[IW'(cand)]) begin
                found = 1'b1;
                pick  = IW'(cand);
            end
        end
    end

    // Next-state logic; the message is latched only at the IDLE decision so
    // later changes on req_text cannot disturb the engine.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        count_d      = count_q;
        err_flag_d   = err_flag_q;
        line_d       = line_q;
        text_d       = text_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    winner_d   = pick;
                    text_d     = bus.req_text[int'(pick)*TW +: TW];
                    line_d     = bus.req_line[pick];
                    err_flag_d = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                count_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion in the same cycle as the timeout takes priority.
                if (completion) begin
                    err_flag_d = 1'b0;
                    state_d    = ACK;
                end else if (count_q == TIMEOUT_LAST) begin
                    err_flag_d = 1'b1;
                    state_d    = ACK;
                end else begin
                    count_d = count_q + 26'd1;
                end
            end
            ACK: begin
                last_grant_d = winner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NUM_REQ - 1);
            winner_q     <= '0;
            count_q      <= '0;
            err_flag_q   <= 1'b0;
            line_q       <= 1'b0;
            text_q       <= '0;
            done_q       <= bus.lcd_done;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            count_q      <= count_d;
            err_flag_q   <= err_flag_d;
            line_q       <= line_d;
            text_q       <= text_d;
            done_q       <= bus.lcd_done;
        end
    end

    // Outputs decode straight from the state so a reset clears them at once.
    assign busy             = (state_q != IDLE);
    assign bus.busy         = busy;
    assign bus.lcd_sendText = (state_q == ISSUE);
    assign bus.grant        = busy ? (NUM_REQ'(1) << winner_q) : '0;
    assign bus.ack          = (state_q == ACK) ? (NUM_REQ'(1) << winner_q) : '0;
    assign bus.err          = (state_q == ACK) && err_flag_q;
    assign bus.lcd_line     = line_q;
    assign bus.lcd_text     = text_q;
endmodule
